// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, FSM states and op predicates.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic logic is_load(mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store-side enables/replication/alignment check and load-side extension.
module mem_align
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  mem_op_e     ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      MEM_LW, MEM_SW: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

  // Little-endian lane select from the captured address
  always_comb begin
    ld_byte   = rdata[{ld_lo, 3'b000} +: 8];
    ld_half   = ld_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_op)
      MEM_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: load_data = {24'd0, ld_byte};
      MEM_LH:  load_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: issues loads/stores on a req/ack port, stalls upstream while pending,
// and hands the final register-write triple to writeback.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [4:0]        write_r_i,
  input  logic              write_en_i,
  input  logic [31:0]       write_data_i,
  input  logic [31:0]       mm_addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [3:0]        mem_op_i,
  output logic              mem_stall_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_be_o,
  output logic [31:0]       dm_wdata_o,
  input  logic              dm_ack_i,
  input  logic [31:0]       dm_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_r_o,
  output logic              wb_en_o,
  output logic [31:0]       wb_data_o,
  output logic              addr_err_o,
  output logic              bus_err_o,
  output logic [31:0]       bad_addr_o
);

  localparam int unsigned CNT_W = 16;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       cap_r;
  logic             cap_en;
  mem_op_e          cap_op;
  logic [31:0]      cap_addr;

  mem_op_e          op_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             misaligned_c;
  logic [31:0]      load_data_c;

  assign op_c        = mem_op_e'(mem_op_i);
  assign mem_stall_o = (state == ACCESS);

  mem_align u_align (
    .op         (op_c),
    .addr_lo    (mm_addr_i[1:0]),
    .store_data (store_data_i),
    .ld_op      (cap_op),
    .ld_lo      (cap_addr[1:0]),
    .rdata      (dm_rdata_i),
    .be         (be_c),
    .wdata      (wdata_c),
    .misaligned (misaligned_c),
    .load_data  (load_data_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_r      <= '0;
      cap_en     <= 1'b0;
      cap_op     <= MEM_NONE;
      cap_addr   <= '0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_be_o    <= '0;
      dm_wdata_o <= '0;
      wb_valid_o <= 1'b0;
      wb_r_o     <= '0;
      wb_en_o    <= 1'b0;
      wb_data_o  <= '0;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      bad_addr_o <= '0;
    end else begin
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (!ex_valid_i) begin
            wb_valid_o <= 1'b0;
          end else if (!(is_load(op_c) || is_store(op_c))) begin
            wb_valid_o <= 1'b1;
            wb_r_o     <= write_r_i;
            wb_en_o    <= write_en_i && (write_r_i != 5'd0);
            wb_data_o  <= write_data_i;
          end else if (misaligned_c) begin
            wb_valid_o <= 1'b1;
            wb_r_o     <= write_r_i;
            wb_en_o    <= 1'b0;
            wb_data_o  <= '0;
            addr_err_o <= 1'b1;
            bad_addr_o <= mm_addr_i;
          end else begin
            state      <= ACCESS;
            cnt        <= '0;
            dm_req_o   <= 1'b1;
            dm_we_o    <= is_store(op_c);
            dm_addr_o  <= {mm_addr_i[ADDR_W-1:2], 2'b00};
            dm_be_o    <= be_c;
            dm_wdata_o <= wdata_c;
            cap_r      <= write_r_i;
            cap_en     <= write_en_i;
            cap_op     <= op_c;
            cap_addr   <= mm_addr_i;
            wb_valid_o <= 1'b0;
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (dm_ack_i) begin
            state      <= IDLE;
            dm_req_o   <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_r_o     <= cap_r;
            wb_en_o    <= is_load(cap_op) && cap_en && (cap_r != 5'd0);
            wb_data_o  <= is_load(cap_op) ? load_data_c : 32'd0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= IDLE;
            dm_req_o   <= 1'b0;
            bus_err_o  <= 1'b1;
            bad_addr_o <= cap_addr;
            wb_valid_o <= 1'b1;
            wb_r_o     <= cap_r;
            wb_en_o    <= 1'b0;
            wb_data_o  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores, alignment, timeout and reset.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  write_r_i;
  logic        write_en_i;
  logic [31:0] write_data_i;
  logic [31:0] mm_addr_i;
  logic [31:0] store_data_i;
  logic [3:0]  mem_op_i;
  logic        mem_stall_o;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_r_o;
  logic        wb_en_o;
  logic [31:0] wb_data_o;
  logic        addr_err_o;
  logic        bus_err_o;
  logic [31:0] bad_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .write_r_i    (write_r_i),
    .write_en_i   (write_en_i),
    .write_data_i (write_data_i),
    .mm_addr_i    (mm_addr_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .mem_stall_o  (mem_stall_o),
    .dm_req_o     (dm_req_o),
    .dm_we_o      (dm_we_o),
    .dm_addr_o    (dm_addr_o),
    .dm_be_o      (dm_be_o),
    .dm_wdata_o   (dm_wdata_o),
    .dm_ack_i     (dm_ack_i),
    .dm_rdata_i   (dm_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_r_o       (wb_r_o),
    .wb_en_o      (wb_en_o),
    .wb_data_o    (wb_data_o),
    .addr_err_o   (addr_err_o),
    .bus_err_o    (bus_err_o),
    .bad_addr_o   (bad_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] r, input logic [31:0] data);
    ex_valid_i   = 1'b1;
    mem_op_i     = op;
    mm_addr_i    = addr;
    store_data_i = sdata;
    write_r_i    = r;
    write_en_i   = 1'b1;
    write_data_i = data;
  endtask

  // Issue a memory op, check the request, ack it in ACCESS cycle ack_at, return stall count
  task automatic access(input string tag, input mem_op_e op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] r, input int ack_at,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_we, output int stalls);
    drive(op, addr, sdata, r, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    chk({tag, ".req"},   32'(dm_req_o), 32'd1);
    chk({tag, ".addr"},  dm_addr_o, {addr[31:2], 2'b00});
    chk({tag, ".be"},    32'(dm_be_o), 32'(exp_be));
    chk({tag, ".wdata"}, dm_wdata_o, exp_wdata);
    chk({tag, ".we"},    32'(dm_we_o), 32'(exp_we));
    stalls = 0;
    for (int c = 1; c <= ack_at; c++) begin
      if (mem_stall_o) stalls++;
      if (c == ack_at) begin
        dm_ack_i   = 1'b1;
        dm_rdata_i = rdata;
      end
      tick();
    end
    dm_ack_i = 1'b0;
  endtask

  initial begin
    int stalls;
    int reqs;
    rst          = 1'b0;
    ex_valid_i   = 1'b0;
    write_r_i    = '0;
    write_en_i   = 1'b0;
    write_data_i = '0;
    mm_addr_i    = '0;
    store_data_i = '0;
    mem_op_i     = MEM_NONE;
    dm_ack_i     = 1'b0;
    dm_rdata_i   = '0;
    tick();
    tick();
    chk("rst.req",      32'(dm_req_o), 32'd0);
    chk("rst.stall",    32'(mem_stall_o), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst.bad_addr", bad_addr_o, 32'd0);
    rst = 1'b1;

    // ALU pass-through, back to back
    drive(MEM_NONE, 32'h0, 32'h0, 5'd5, 32'h1234);
    tick();
    chk("alu1.valid", 32'(wb_valid_o), 32'd1);
    chk("alu1.r",     32'(wb_r_o), 32'd5);
    chk("alu1.data",  wb_data_o, 32'h1234);
    chk("alu1.en",    32'(wb_en_o), 32'd1);
    chk("alu1.stall", 32'(mem_stall_o), 32'd0);
    drive(MEM_NONE, 32'h0, 32'h0, 5'd6, 32'h5678);
    tick();
    chk("alu2.r",     32'(wb_r_o), 32'd6);
    chk("alu2.data",  wb_data_o, 32'h5678);
    chk("alu2.stall", 32'(mem_stall_o), 32'd0);
    drive(MEM_NONE, 32'h0, 32'h0, 5'd0, 32'h9);
    tick();
    chk("zero.en",    32'(wb_en_o), 32'd0);
    ex_valid_i = 1'b0;
    tick();
    chk("idle.valid", 32'(wb_valid_o), 32'd0);

    // LW acked in the third ACCESS cycle
    access("lw", MEM_LW, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, stalls);
    chk("lw.stalls", 32'(stalls), 32'd3);
    chk("lw.valid",  32'(wb_valid_o), 32'd1);
    chk("lw.r",      32'(wb_r_o), 32'd7);
    chk("lw.data",   wb_data_o, 32'hDEADBEEF);
    chk("lw.en",     32'(wb_en_o), 32'd1);
    chk("lw.req_off", 32'(dm_req_o), 32'd0);

    access("lb", MEM_LB, 32'h103, 32'h0, 5'd8, 1, 32'h80AA5511, 4'b1000, 32'h0, 1'b0, stalls);
    chk("lb.data", wb_data_o, 32'hFFFFFF80);
    access("lbu", MEM_LBU, 32'h103, 32'h0, 5'd8, 2, 32'h80AA5511, 4'b1000, 32'h0, 1'b0, stalls);
    chk("lbu.data", wb_data_o, 32'h00000080);
    access("lh", MEM_LH, 32'h102, 32'h0, 5'd9, 1, 32'h80AA5511, 4'b1100, 32'h0, 1'b0, stalls);
    chk("lh.data", wb_data_o, 32'hFFFF80AA);
    access("lhu", MEM_LHU, 32'h000, 32'h0, 5'd9, 1, 32'h80AA9511, 4'b0011, 32'h0, 1'b0, stalls);
    chk("lhu.data", wb_data_o, 32'h00009511);

    access("sh", MEM_SH, 32'h202, 32'h0000BEEF, 5'd10, 2, 32'h0, 4'b1100, 32'hBEEFBEEF, 1'b1, stalls);
    chk("sh.valid", 32'(wb_valid_o), 32'd1);
    chk("sh.en",    32'(wb_en_o), 32'd0);
    access("sb", MEM_SB, 32'h101, 32'h12345678, 5'd11, 1, 32'h0, 4'b0010, 32'h78787878, 1'b1, stalls);
    chk("sb.en", 32'(wb_en_o), 32'd0);

    // Misaligned word load
    drive(MEM_LW, 32'h1002, 32'h0, 5'd12, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    chk("mis.req",      32'(dm_req_o), 32'd0);
    chk("mis.addr_err", 32'(addr_err_o), 32'd1);
    chk("mis.bad_addr", bad_addr_o, 32'h1002);
    chk("mis.valid",    32'(wb_valid_o), 32'd1);
    chk("mis.en",       32'(wb_en_o), 32'd0);
    chk("mis.stall",    32'(mem_stall_o), 32'd0);
    tick();
    chk("mis.pulse",    32'(addr_err_o), 32'd0);

    // Ack coinciding with the timeout cycle wins
    access("edge", MEM_LW, 32'h180, 32'h0, 5'd13, 4, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, stalls);
    chk("edge.bus_err", 32'(bus_err_o), 32'd0);
    chk("edge.data",    wb_data_o, 32'h0BADF00D);
    chk("edge.en",      32'(wb_en_o), 32'd1);

    // Ack while idle has no effect
    dm_ack_i = 1'b1;
    tick();
    dm_ack_i = 1'b0;
    chk("idle_ack.valid", 32'(wb_valid_o), 32'd0);
    chk("idle_ack.req",   32'(dm_req_o), 32'd0);

    // Timeout with no ack
    drive(MEM_LW, 32'h300, 32'h0, 5'd14, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (!dm_req_o) break;
      reqs++;
      tick();
    end
    chk("to.req_cycles", 32'(reqs), 32'd4);
    chk("to.bus_err",    32'(bus_err_o), 32'd1);
    chk("to.bad_addr",   bad_addr_o, 32'h300);
    chk("to.valid",      32'(wb_valid_o), 32'd1);
    chk("to.en",         32'(wb_en_o), 32'd0);
    chk("to.stall",      32'(mem_stall_o), 32'd0);
    tick();
    chk("to.pulse",      32'(bus_err_o), 32'd0);

    // Retry, then reset mid-access
    drive(MEM_LW, 32'h400, 32'h0, 5'd15, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    chk("retry.req", 32'(dm_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst.req",      32'(dm_req_o), 32'd0);
    chk("arst.stall",    32'(mem_stall_o), 32'd0);
    chk("arst.addr",     dm_addr_o, 32'd0);
    chk("arst.be",       32'(dm_be_o), 32'd0);
    chk("arst.bad_addr", bad_addr_o, 32'd0);
    chk("arst.wb_r",     32'(wb_r_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post.req", 32'(dm_req_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the MIPS pipeline, directly downstream of the execute stage.
- Takes execute results: destination register, write enable, ALU/write data, memory address, store data and memory-op code.
- Performs byte/half/word loads and stores over a req/ack data-memory port and stalls upstream while an access is pending.
- Presents the final register-write triple to writeback.

Parameters:
- ADDR_W, 32, data-memory address width (low bits of mm_addr_i).
- TIMEOUT, 255, ACCESS cycles without dm_ack before a bus error is declared (1..65535).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ex_valid_i  input  1  execute-stage result valid this cycle.
- write_r_i  input  5  destination register.
- write_en_i  input  1  register write enable.
- write_data_i  input  32  ALU/link result for non-memory ops.
- mm_addr_i  input  32  effective address.
- store_data_i  input  32  rt value for stores.
- mem_op_i  input  4  MEM_* code (package).
- mem_stall_o  output  1  upstream must hold its outputs.
- dm_req_o  output  1  memory request.
- dm_we_o  output  1  1 = store.
- dm_addr_o  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dm_be_o  output  4  byte-lane enables.
- dm_wdata_o  output  32  lane-replicated store data.
- dm_ack_i  input  1  access complete; rdata valid the same cycle.
- dm_rdata_i  input  32  read word.
- wb_valid_o  output  1  writeback triple valid.
- wb_r_o  output  5  writeback register.
- wb_en_o  output  1  writeback enable.
- wb_data_o  output  32  writeback data.
- addr_err_o  output  1  one-cycle misalignment pulse.
- bus_err_o  output  1  one-cycle timeout pulse.
- bad_addr_o  output  32  address of the last faulting access.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: dm_req, dm_we, dm_addr, dm_be, dm_wdata, wb_*, both error flags, bad_addr. Timeout counter cleared.
- Reset during ACCESS drops dm_req immediately. The memory side must discard the request.
- States:
  - IDLE: accepts ex_valid_i.
  - ACCESS: request outstanding.
- mem_stall_o = (state==ACCESS). It is combinational from state only. ex_* inputs are ignored while in ACCESS.
- IDLE, ex_valid_i=1, mem_op_i=MEM_NONE: wb_* registered from write_r_i/write_en_i/write_data_i. wb_valid_o=1 next cycle (latency 1). Back-to-back ops are accepted every cycle.
- IDLE, ex_valid_i=0: wb_valid_o<=0.
- IDLE, aligned memory op:
  - Register dm_addr, dm_be, dm_wdata and dm_we.
  - dm_req_o=1 from the next cycle; go to ACCESS; clear the counter.
  - wb_valid_o<=0 meanwhile.
- Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; bytes are always aligned.
- Misaligned op in IDLE:
  - No request; stay IDLE.
  - Next cycle: addr_err_o=1 for 1 cycle, bad_addr_o=mm_addr_i, wb_valid_o=1, wb_en_o=0.
- Lanes are little-endian, selected by addr[1:0]:
  - SB: be = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW: be = 4'b1111.
  - Loads assert the same be pattern.
- ACCESS: dm_req_o and all dm_* outputs are held stable until ack. Counter increments each cycle.
- dm_ack_i=1 in ACCESS:
  - dm_req_o<=0; state<=IDLE.
  - wb_valid_o<=1 next cycle with the captured write_r.
  - Load: wb_data_o = selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_en_o = captured write_en.
  - Store: wb_en_o=0.
- An operation accepted in the cycle after ack can issue a new request; minimum one idle dm_req cycle between accesses.
- Counter reaches TIMEOUT without ack:
  - dm_req_o<=0; state<=IDLE.
  - bus_err_o pulses 1 cycle; bad_addr_o = captured addr.
  - wb_valid_o=1, wb_en_o=0.
- Ack in the same cycle the counter reaches TIMEOUT: ack wins, no bus_err.
- dm_ack_i in IDLE is ignored.
- wb_en_o is forced 0 whenever wb_r_o==0 (register $zero).

Decomposition:
- Package mem_pkg:
  - MEM_NONE=0, MEM_LB=1, MEM_LBU=2, MEM_LH=3, MEM_LHU=4, MEM_LW=5, MEM_SB=6, MEM_SH=7, MEM_SW=8.
  - State encodings: IDLE, ACCESS.
  - Helper predicates is_load/is_store.
- Sub-module mem_align: purely combinational.
  - Store side: (op, addr[1:0], store_data) -> (be, wdata, misaligned).
  - Load side: (op, addr[1:0], rdata) -> extended load data.
- mem_access holds the FSM, counter and registers.

Test Plan:
- ALU pass-through: ex_valid=1, op=NONE, r=5, data=0x1234 on two consecutive cycles -> wb_valid=1, r=5, data=0x1234 one cycle later each; mem_stall never asserted.
- LW addr 0x100, dm_ack after 3 cycles with rdata 0xDEADBEEF -> dm_addr=0x100, be=1111, stall high 3 cycles, wb_data=0xDEADBEEF, wb_en=1.
- LB addr 0x103, rdata 0x80AA5511 -> be=1000, wb_data=0xFFFFFF80; the same with LBU -> 0x00000080.
- SH addr 0x202, store_data 0x0000BEEF -> dm_we=1, be=1100, wdata=0xBEEFBEEF; on ack wb_valid=1, wb_en=0.
- LW addr 0x1002 -> no dm_req, addr_err pulse, bad_addr=0x1002, wb_en=0.
- TIMEOUT=4, LW with no ack -> dm_req high 4 cycles, bus_err pulse, state IDLE; then assert rst low mid-access on a retry -> dm_req=0 immediately and all outputs 0.
